// File: rtl/lpgbt_downlink_frame_source.sv
// lpGBT downlink payload builder: user-word FIFO plus two 2-bit-per-frame
// byte serialisers (IC, EC), with idle substitution and underflow counting.

module lpgbt_pair_ser (
    input  logic       S_AXI_ACLK,
    input  logic       S_AXI_ARESETN,
    input  logic       flush_i,
    input  logic       frame_evt_i,
    input  logic [7:0] byte_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic [1:0] pair_o
);
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic [0:0] state;
    logic [7:0] hold, shreg;
    logic       hold_full;
    logic [1:0] cnt;

    assign ready_o = !hold_full;

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN || flush_i) begin
            state     <= ST_IDLE;
            hold      <= '0;
            hold_full <= 1'b0;
            shreg     <= '0;
            cnt       <= '0;
            pair_o    <= 2'b11;
        end else begin
            // Load and hand-off are exclusive: load needs !hold_full, hand-off needs hold_full.
            if (valid_i && !hold_full) begin
                hold      <= byte_i;
                hold_full <= 1'b1;
            end
            if (frame_evt_i) begin
                if (state == ST_IDLE) begin
                    if (hold_full) begin
                        shreg     <= hold;
                        pair_o    <= hold[7:6];
                        cnt       <= 2'd1;
                        hold_full <= 1'b0;
                        state     <= ST_SHIFT;
                    end else begin
                        pair_o <= 2'b11;
                    end
                end else begin
                    cnt <= cnt + 2'd1;
                    case (cnt)
                        2'd1:    pair_o <= shreg[5:4];
                        2'd2:    pair_o <= shreg[3:2];
                        default: begin
                            pair_o <= shreg[1:0];
                            state  <= ST_IDLE;
                        end
                    endcase
                end
            end
        end
    end
endmodule

module lpgbt_downlink_frame_source #(
    parameter int          FIFO_DEPTH = 16,
    parameter logic [31:0] IDLE_WORD  = 32'h0000_0000,
    parameter int          LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             S_AXI_ACLK,
    input  logic             S_AXI_ARESETN,
    input  logic             enable_i,
    input  logic             flush_i,
    input  logic             frame_stb_i,
    input  logic [31:0]      user_data_i,
    input  logic             user_valid_i,
    output logic             user_ready_o,
    input  logic [7:0]       ic_byte_i,
    input  logic             ic_valid_i,
    output logic             ic_ready_o,
    input  logic [7:0]       ec_byte_i,
    input  logic             ec_valid_i,
    output logic             ec_ready_o,
    output logic [31:0]      downlinkUserData_o,
    output logic [1:0]       downlinkIcData_o,
    output logic [1:0]       downlinkEcData_o,
    output logic             downlinkValid_o,
    output logic [LVL_W-1:0] fifo_level_o,
    output logic [15:0]      underflow_cnt_o
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [31:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [LVL_W-1:0] level;
    logic             frame_evt, push, pop;

    logic [1:0][7:0] ser_byte;
    logic [1:0]      ser_valid, ser_ready;
    logic [1:0][1:0] ser_pair;

    // Flush wins over a same-cycle strobe or push.
    assign frame_evt    = frame_stb_i && enable_i && !flush_i;
    assign user_ready_o = (level != LVL_W'(FIFO_DEPTH));
    assign push         = user_valid_i && user_ready_o && !flush_i;
    assign pop          = frame_evt && (level != '0);
    assign fifo_level_o = level;

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESETN && push)
            mem[wr_ptr] <= user_data_i;
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN || flush_i) begin
            wr_ptr             <= '0;
            rd_ptr             <= '0;
            level              <= '0;
            downlinkUserData_o <= IDLE_WORD;
            downlinkValid_o    <= 1'b0;
            if (!S_AXI_ARESETN)
                underflow_cnt_o <= '0;
        end else begin
            downlinkValid_o <= frame_evt;
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: ;
            endcase
            if (frame_evt) begin
                if (level != '0) begin
                    downlinkUserData_o <= mem[rd_ptr];
                end else begin
                    downlinkUserData_o <= IDLE_WORD;
                    if (underflow_cnt_o != 16'hFFFF)
                        underflow_cnt_o <= underflow_cnt_o + 16'd1;
                end
            end
        end
    end

    // Channel 0 = IC, channel 1 = EC.
    assign ser_byte  = {ec_byte_i, ic_byte_i};
    assign ser_valid = {ec_valid_i, ic_valid_i};

    for (genvar g = 0; g < 2; g++) begin : g_ser
        lpgbt_pair_ser u_ser (
            .S_AXI_ACLK   (S_AXI_ACLK),
            .S_AXI_ARESETN(S_AXI_ARESETN),
            .flush_i      (flush_i),
            .frame_evt_i  (frame_evt),
            .byte_i       (ser_byte[g]),
            .valid_i      (ser_valid[g]),
            .ready_o      (ser_ready[g]),
            .pair_o       (ser_pair[g])
        );
    end

    assign ic_ready_o       = ser_ready[0];
    assign ec_ready_o       = ser_ready[1];
    assign downlinkIcData_o = ser_pair[0];
    assign downlinkEcData_o = ser_pair[1];
endmodule
